// File: rtl/blink_pkg.sv
// Shared types and sizes for the LED blink sequencer.
// State encoding for the sequencer FSM plus default field widths.
package blink_pkg;

    localparam int CNT_W      = 16;
    localparam int DUR_W      = 8;
    localparam int TICK_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Time-base pulse: one-cycle tick on each rising edge of the selected count bit.
// Latency: tick is combinational from the count, edge history is one register.
// Backpressure: none; ticks are not stored, a consumer that is not listening misses them.
module tick_gen
    import blink_pkg::*;
#(
    parameter int CNT_W = blink_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      currentCount,
    input  logic [TICK_SEL_W-1:0] sel,
    output logic                  tick
);

    logic bit_cur;
    logic prev_q;

    assign bit_cur = currentCount[sel];

    // Reloading to 1 keeps a high bit at reset release from looking like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= bit_cur;
        end
    end

    assign tick = bit_cur & ~prev_q;

endmodule

// File: rtl/blink_sequencer.sv
// Runs programmed on/off blink sequences on blink_wire from commands.
// Latency: accept -> blink_wire/busy high in 1 cycle; phase changes 1 cycle after the ending tick.
// Backpressure: cmd_ready is high only while idle and enabled; ena low freezes everything.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CNT_W = blink_pkg::CNT_W,
    parameter int DUR_W = blink_pkg::DUR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [CNT_W-1:0]      currentCount,
    input  logic [TICK_SEL_W-1:0] tick_sel,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DUR_W-1:0]      cmd_on,
    input  logic [DUR_W-1:0]      cmd_off,
    input  logic [DUR_W-1:0]      cmd_reps,
    input  logic                  abort,
    output logic                  blink_wire,
    output logic                  busy,
    output logic                  done,
    output logic [DUR_W-1:0]      reps_left
);

    localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

    state_t                  state_q, state_d;
    logic [DUR_W-1:0]        timer_q, timer_d;
    logic [DUR_W-1:0]        left_q, left_d;
    logic [DUR_W-1:0]        on_q, on_d;
    logic [DUR_W-1:0]        off_q, off_d;
    logic [DUR_W-1:0]        reps_q, reps_d;
    logic [TICK_SEL_W-1:0]   sel_q, sel_d;
    logic                    blink_q, blink_d;
    logic                    done_q, done_d;
    logic                    tick;

    tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .currentCount (currentCount),
        .sel          (sel_q),
        .tick         (tick)
    );

    assign cmd_ready  = (state_q == IDLE) & ena & rst_n;
    assign blink_wire = blink_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign reps_left  = left_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        left_d  = left_q;
        on_d    = on_q;
        off_d   = off_q;
        reps_d  = reps_q;
        sel_d   = sel_q;
        blink_d = blink_q;
        done_d  = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        sel_d  = tick_sel;
                        on_d   = cmd_on;
                        off_d  = cmd_off;
                        reps_d = cmd_reps;
                        if (cmd_on == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ON;
                            timer_d = cmd_on;
                            left_d  = cmd_reps;
                            blink_d = 1'b1;
                        end
                    end
                end
                ON, OFF: begin
                    if (abort) begin
                        state_d = IDLE;
                        blink_d = 1'b0;
                        left_d  = '0;
                    end else if (tick) begin
                        if (timer_q > ONE) begin
                            timer_d = timer_q - ONE;
                        end else if (state_q == ON && off_q != '0) begin
                            state_d = OFF;
                            timer_d = off_q;
                            blink_d = 1'b0;
                        end else if (reps_q != '0 && left_q == ONE) begin
                            state_d = IDLE;
                            blink_d = 1'b0;
                            left_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            // Rep-end: infinite mode (reps_q==0) keeps left at 0.
                            if (reps_q != '0 && left_q > ONE) begin
                                left_d = left_q - ONE;
                            end
                            state_d = ON;
                            timer_d = on_q;
                            blink_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            left_q  <= '0;
            on_q    <= '0;
            off_q   <= '0;
            reps_q  <= '0;
            sel_q   <= '0;
            blink_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            left_q  <= left_d;
            on_q    <= on_d;
            off_q   <= off_d;
            reps_q  <= reps_d;
            sel_q   <= sel_d;
            blink_q <= blink_d;
            done_q  <= done_d;
        end
    end

endmodule
